// File: rtl/alu_seq_pkg.sv
// Shared types, limits and golden-model function for the ALU command sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: ALU mode enum, sequencer FSM state enum, settle-window bounds and
// expectedOut(), which returns {cout, result} for a mode, operands and carry-in.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        MODE_NOT  = 3'b000,   // ~A
        MODE_ADD  = 3'b001,   // A+B+cin, carry out
        MODE_AND  = 3'b010,
        MODE_OR   = 3'b011,
        MODE_XOR  = 3'b100,
        MODE_SHL  = 3'b101,   // {A[W-2:0],cin}, cout = A[W-1]
        MODE_ZERO = 3'b110,
        MODE_ONE  = 3'b111
    } aluMode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } seqState_e;

    localparam int SETTLE_MIN   = 1;
    localparam int SETTLE_MAX   = 15;
    localparam int SETTLE_CNT_W = 4;

    // Widest operand the golden function handles; callers zero-extend into it
    // and pass their real width so carries and masks land on the right bit.
    localparam int EXP_MAX_W = 32;

    // Returns {cout, result}; result bits at and above 'width' are always zero.
    function automatic logic [EXP_MAX_W:0] expectedOut(
        input aluMode_e                mode,
        input logic [EXP_MAX_W-1:0]    a,
        input logic [EXP_MAX_W-1:0]    b,
        input logic                    cin,
        input int unsigned             width
    );
        logic [EXP_MAX_W-1:0] mask;
        logic [EXP_MAX_W:0]   sum;
        logic [EXP_MAX_W-1:0] res;
        logic                 co;
        mask = (EXP_MAX_W'(1) << width) - EXP_MAX_W'(1);
        sum  = {1'b0, a} + {1'b0, b} + {{EXP_MAX_W{1'b0}}, cin};
        res  = '0;
        co   = 1'b0;
        case (mode)
            MODE_NOT:  res = ~a;
            MODE_ADD: begin
                res = sum[EXP_MAX_W-1:0];
                // carry is the bit just above the operand width; wraps silently
                co  = |(sum & ((EXP_MAX_W + 1)'(1) << width));
            end
            MODE_AND:  res = a & b;
            MODE_OR:   res = a | b;
            MODE_XOR:  res = a ^ b;
            MODE_SHL: begin
                res = {a[EXP_MAX_W-2:0], cin};
                co  = |(a & (EXP_MAX_W'(1) << (width - 1)));
            end
            MODE_ZERO: res = '0;
            MODE_ONE:  res = '1;
            default:   res = '0;
        endcase
        return {co, res & mask};
    endfunction

endpackage

// File: rtl/alu_expect.sv
// Golden model of the 4-bit ALU: expected {cout,result} for the current drive.
// Latency: combinational.
// Backpressure: none.
//
// Ports: mode/a/b/cin = the values being driven to the ALU;
//        expResult/expCout = what a correct ALU must return for them.
module alu_expect
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] expResult,
    output logic             expCout
);

    logic [EXP_MAX_W:0] full;

    assign full      = expectedOut(aluMode_e'(mode), EXP_MAX_W'(a), EXP_MAX_W'(b),
                                   cin, WIDTH);
    assign expResult = full[WIDTH-1:0];
    assign expCout   = full[EXP_MAX_W];

    // Upper result bits are masked to zero by the function; they carry no data.
    if (WIDTH < EXP_MAX_W) begin : gHi
        logic unusedHi;
        assign unusedHi = ^full[EXP_MAX_W-1:WIDTH];
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives one op into the ALU, waits a settle window, captures and checks the result.
// Latency: accept at edge N -> rsp_valid at edge N+SETTLE_CYCLES; one op per SETTLE_CYCLES+2.
// Backpressure: cmd_ready low while an op is in flight; rsp_* held until rsp_ready.
//
// Ports: cmd_* = command in (valid/ready); alu_* out = registered ALU drive,
//        alu_result/alu_cout in = ALU outputs; rsp_* = captured result + golden
//        mismatch flag (valid/ready); busy = not idle.
// Option: ALU_SEQ_CHAIN_EN adds cmd_chain, taking carry-in from the last rsp_cout.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [2:0]       alu_mode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_mismatch,
    output logic             busy
);

    // Out-of-range settle windows are clamped into the counter's range.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN :
                                (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_EFF - 1);

    seqState_e               curState, nextState;
    logic [SETTLE_CNT_W-1:0] settleCnt;
    logic                    accept, capture, respDone, cinSel;
    logic [WIDTH-1:0]        expResult;
    logic                    expCout;

    assign accept   = cmd_valid && cmd_ready;
    assign capture  = (curState == ST_SETTLE) && (settleCnt == '0);
    assign respDone = (curState == ST_RESP) && rsp_ready;

`ifdef ALU_SEQ_CHAIN_EN
    // rsp_cout still holds the previous op's carry-out (cleared by reset).
    assign cinSel = cmd_chain ? rsp_cout : cmd_cin;
`else
    assign cinSel = cmd_cin;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            curState <= ST_IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (curState)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) nextState = ST_SETTLE;
            end
            ST_SETTLE: if (settleCnt == '0) nextState = ST_RESP;
            ST_RESP:   if (rsp_ready) nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    // The golden model sees the same registered drive as the ALU, so chained
    // carries are checked with the carry actually applied.
    alu_expect #(.WIDTH(WIDTH)) uExpect (
        .mode      (alu_mode),
        .a         (alu_a),
        .b         (alu_b),
        .cin       (alu_cin),
        .expResult (expResult),
        .expCout   (expCout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_mode     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_cin      <= 1'b0;
            settleCnt    <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_cout     <= 1'b0;
            rsp_mismatch <= 1'b0;
        end else begin
            // alu_* only changes on accept, so it keeps the last command while idle.
            if (accept) begin
                alu_mode  <= cmd_mode;
                alu_a     <= cmd_a;
                alu_b     <= cmd_b;
                alu_cin   <= cinSel;
                settleCnt <= SETTLE_LOAD;
            end else if ((curState == ST_SETTLE) && (settleCnt != '0)) begin
                settleCnt <= settleCnt - SETTLE_CNT_W'(1);
            end

            if (capture) begin
                rsp_valid    <= 1'b1;
                rsp_result   <= alu_result;
                rsp_cout     <= alu_cout;
                rsp_mismatch <= (alu_result != expResult) || (alu_cout != expCout);
            end else if (respDone) begin
                rsp_valid    <= 1'b0;
                rsp_mismatch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (WIDTH=4, SETTLE_CYCLES=4).
// A timeline model predicts every output each cycle; directed tests pin literals.
// Define ALU_SEQ_CHAIN_EN to also exercise the carry-chain option.
module tb_alu_op_sequencer;

    localparam int W = 4;
    localparam int S = 4;

    logic         clock, reset;
    logic         cmd_valid, cmd_ready;
    logic [2:0]   cmd_mode;
    logic [W-1:0] cmd_a, cmd_b;
    logic         cmd_cin, cmdChain;
    logic [2:0]   alu_mode;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_cin, alu_cout;
    logic         rsp_valid, rsp_ready, rsp_cout, rsp_mismatch, busy;
    logic [W-1:0] rsp_result;

    int tests = 0;
    int fails = 0;
    int tbEdge = 0;

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_cin      (cmd_cin),
`ifdef ALU_SEQ_CHAIN_EN
        .cmd_chain    (cmdChain),
`endif
        .alu_mode     (alu_mode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) tbEdge++;

    // Plain-arithmetic statement of the mode table: returns {cout, result}.
    function automatic logic [4:0] specAlu(input int mode, input int a, input int b, input int cin);
        int r, c;
        r = 0;
        c = 0;
        case (mode)
            0: r = ~a;
            1: begin r = a + b + cin; c = r >> 4; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a << 1) | cin; c = a >> 3; end
            6: r = 0;
            7: r = 15;
            default: r = 0;
        endcase
        specAlu = {c[0], r[3:0]};
    endfunction

    // The ALU attached to the DUT: correct except AND of 0xC,0xA returns 0xF.
    function automatic logic [4:0] benchAlu(input int mode, input int a, input int b, input int cin);
        benchAlu = specAlu(mode, a, b, cin);
        if (mode == 2 && a == 12 && b == 10) benchAlu = 5'h0F;
    endfunction

    always_comb {alu_cout, alu_result} = benchAlu(alu_mode, alu_a, alu_b, alu_cin);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    logic       mBusy = 0, mValid = 0, mLastCout = 0;
    time        mDueTime = 0;
    logic [3:0] mRes = 0;
    logic       mCout = 0, mMis = 0;
    logic [2:0] mAluMode = 0;
    logic [3:0] mAluA = 0, mAluB = 0;
    logic       mAluCin = 0;

    always @(posedge clock or negedge reset) begin
        logic [4:0] got, gold;
        logic       cinUsed;
        if (!reset) begin
            mBusy = 0; mValid = 0; mLastCout = 0;
            mAluMode = 0; mAluA = 0; mAluB = 0; mAluCin = 0;
            mRes = 0; mCout = 0; mMis = 0;
        end else if (mValid && rsp_ready) begin
            mValid = 0;
            mBusy  = 0;
        end else if (!mBusy && cmd_valid) begin
            cinUsed = cmd_cin;
`ifdef ALU_SEQ_CHAIN_EN
            if (cmdChain) cinUsed = mLastCout;
`endif
            mAluMode = cmd_mode; mAluA = cmd_a; mAluB = cmd_b; mAluCin = cinUsed;
            got  = benchAlu(cmd_mode, cmd_a, cmd_b, cinUsed);
            gold = specAlu(cmd_mode, cmd_a, cmd_b, cinUsed);
            mRes = got[3:0]; mCout = got[4]; mMis = (got != gold);
            mBusy = 1;
            mDueTime = $time + S * 10;
        end else if (mBusy && !mValid && $time == mDueTime) begin
            mValid = 1;
            mLastCout = mCout;
        end
    end

    always @(negedge clock) begin
        check("m_cmd_ready", cmd_ready, !mBusy);
        check("m_busy", busy, mBusy);
        check("m_rsp_valid", rsp_valid, mValid);
        check("m_rsp_mismatch", rsp_mismatch, mValid ? mMis : 1'b0);
        check("m_alu_mode", alu_mode, mAluMode);
        check("m_alu_a", alu_a, mAluA);
        check("m_alu_b", alu_b, mAluB);
        check("m_alu_cin", alu_cin, mAluCin);
        if (mValid) begin
            check("m_rsp_result", rsp_result, mRes);
            check("m_rsp_cout", rsp_cout, mCout);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic doCmd(input logic [2:0] mode, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic chain, output int accEdge);
        int n;
        n = 0;
        while (!cmd_ready && n < 40) begin @(posedge clock); #1; n++; end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_a = a; cmd_b = b; cmd_cin = cin; cmdChain = chain;
        @(posedge clock);
        #1;
        accEdge   = tbEdge;
        cmd_valid = 1'b0;
        cmdChain  = 1'b0;
    endtask

    task automatic waitRsp(input string name, input int accEdge, input logic [3:0] er,
                           input logic ec, input logic em);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clock); #1; n++; end
        check({name, "_latency"}, tbEdge - accEdge, S);
        check({name, "_result"}, rsp_result, er);
        check({name, "_cout"}, rsp_cout, ec);
        check({name, "_mismatch"}, rsp_mismatch, em);
    endtask

    task automatic runOp(input string name, input logic [2:0] mode, input logic [3:0] a,
                         input logic [3:0] b, input logic cin, input logic [3:0] er,
                         input logic ec, input logic em);
        int acc;
        doCmd(mode, a, b, cin, 1'b0, acc);
        waitRsp(name, acc, er, ec, em);
        @(posedge clock); #1;
        check({name, "_valid_drop"}, rsp_valid, 1'b0);
        check({name, "_ready_back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        int acc;
        cmd_valid = 0; cmd_mode = 0; cmd_a = 0; cmd_b = 0; cmd_cin = 0; cmdChain = 0;
        rsp_ready = 1;
        reset = 1;
        #1 reset = 0;
        #2;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_alu_a", alu_a, 4'h0);
        check("rst_rsp_result", rsp_result, 4'h0);
        #20 reset = 1;
        @(posedge clock); #1;

        runOp("add98", 3'b001, 4'h9, 4'h8, 1'b1, 4'h2, 1'b1, 1'b0);
        runOp("shlB",  3'b101, 4'hB, 4'h0, 1'b0, 4'h6, 1'b1, 1'b0);
        runOp("zero",  3'b110, 4'h5, 4'h3, 1'b1, 4'h0, 1'b0, 1'b0);
        runOp("ones",  3'b111, 4'h5, 4'h3, 1'b0, 4'hF, 1'b0, 1'b0);
        runOp("not3",  3'b000, 4'h3, 4'h0, 1'b0, 4'hC, 1'b0, 1'b0);
        runOp("or5A",  3'b011, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0);
        runOp("addFF", 3'b001, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

        // Backpressure: response held for 10 cycles.
        rsp_ready = 0;
        doCmd(3'b100, 4'h6, 4'h3, 1'b0, 1'b0, acc);
        waitRsp("xorBp", acc, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("bp_valid_hold", rsp_valid, 1'b1);
            check("bp_result_hold", rsp_result, 4'h5);
            check("bp_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1;
        @(posedge clock); #1;
        check("bp_valid_drop", rsp_valid, 1'b0);
        check("bp_ready_back", cmd_ready, 1'b1);

        // Faulty ALU answer flagged.
        runOp("andFault", 3'b010, 4'hC, 4'hA, 1'b0, 4'hF, 1'b0, 1'b1);

        // Reset two cycles into the settle window.
        doCmd(3'b001, 4'h1, 4'h1, 1'b0, 1'b0, acc);
        @(posedge clock); #1;
        @(posedge clock); #1;
        #2 reset = 0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_alu_a", alu_a, 4'h0);
        check("mid_rst_alu_mode", alu_mode, 3'h0);
        check("mid_rst_rsp_result", rsp_result, 4'h0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        #10 reset = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            check("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        runOp("postRst", 3'b001, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0);

`ifdef ALU_SEQ_CHAIN_EN
        runOp("chainLo", 3'b001, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        doCmd(3'b001, 4'h0, 4'h0, 1'b0, 1'b1, acc);
        check("chain_alu_cin", alu_cin, 1'b1);
        waitRsp("chainHi", acc, 4'h1, 1'b0, 1'b0);
        @(posedge clock); #1;
`endif

        repeat (3) @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
